// File: rtl/fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fetch_buffer                                               |
// | Description : Small FIFO between instruction fetch and decode. It holds  |
// |               PC/instruction pairs in arrival order, reports occupancy   |
// |               and is emptied in one cycle by a branch/jump flush.        |
// | Option      : FETCH_BUFFER_BYPASS_EN - when defined, an incoming pair    |
// |               arriving at an empty buffer is presented on the outputs    |
// |               in the same cycle and is stored only if it is not taken.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   1      single clock, rising edge                       |
// |   reset      in   1      synchronous, active-high                        |
// |   flush      in   1      discard all held and incoming entries           |
// |   in_valid   in   1      upstream pair valid                             |
// |   pc_in      in   32     upstream PC                                     |
// |   inst_in    in   32     upstream instruction word                       |
// |   in_ready   out  1      pair accepted this cycle                        |
// |   out_valid  out  1      pc_out/inst_out hold a valid entry              |
// |   pc_out     out  32     head PC (0 when not valid)                      |
// |   inst_out   out  32     head instruction (NOP when not valid)           |
// |   out_ready  in   1      decode consumes the head this cycle             |
// |   count      out  log2(DEPTH)+1  current occupancy                       |
// +--------------------------------------------------------------------------+

module fetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              inst_in,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              pc_out,
  output logic [31:0]              inst_out,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned        c_ptr_w   = $clog2(DEPTH);
  localparam int unsigned        c_cnt_w   = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  // Entry storage: deliberately not reset, only the pointers/count are.
  logic [31:0]        pc_mem_q   [DEPTH];
  logic [31:0]        inst_mem_q [DEPTH];

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q,  count_d;

  logic               w_empty;
  logic               w_full;
  logic               w_push;   // pair accepted from upstream
  logic               w_pop;    // stored head consumed by decode
  logic               w_store;  // accepted pair written into storage

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == c_full);

  // Full blocks acceptance even when decode pops in the same cycle; this
  // keeps in_ready free of any dependency on out_ready.
  assign in_ready = !w_full && !flush;
  assign w_push   = in_valid && in_ready && !flush;
  assign count    = count_q;

`ifdef FETCH_BUFFER_BYPASS_EN
  logic w_bypass;

  // An empty buffer forwards the incoming pair straight to decode.
  assign w_bypass  = w_empty && in_valid && !flush;
  assign out_valid = !w_empty || w_bypass;

  // Storage is only popped when it actually holds something; a bypassed
  // pair taken by decode never enters storage at all.
  assign w_pop     = !w_empty && out_ready && !flush;
  assign w_store   = w_push && !(w_bypass && out_ready);

  always_comb begin
    pc_out   = '0;
    inst_out = NOP;
    if (!w_empty) begin
      pc_out   = pc_mem_q[rd_ptr_q];
      inst_out = inst_mem_q[rd_ptr_q];
    end else if (w_bypass) begin
      pc_out   = pc_in;
      inst_out = inst_in;
    end
  end
`else
  // Registered-only output path: a pushed pair becomes visible one cycle
  // after it is accepted.
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_store   = w_push;

  always_comb begin
    pc_out   = '0;
    inst_out = NOP;
    if (out_valid) begin
      pc_out   = pc_mem_q[rd_ptr_q];
      inst_out = inst_mem_q[rd_ptr_q];
    end
  end
`endif

  // Next-state for pointers and occupancy. Flush wins over push/pop and
  // returns everything to the origin rather than just equalising pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps the pointers.
      if (w_store) begin
        wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      case ({w_store, w_pop})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A write during a reset cycle lands in a slot the cleared pointers
  // treat as empty, so it needs no reset qualification.
  always_ff @(posedge clk) begin
    if (w_store) begin
      pc_mem_q[wr_ptr_q]   <= pc_in;
      inst_mem_q[wr_ptr_q] <= inst_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none

module tb_fetch_buffer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] pc_in, inst_in;
  logic        in_ready, out_valid;
  logic [31:0] pc_out, inst_out;
  logic [2:0]  count;

  fetch_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .pc_in     (pc_in),
    .inst_in   (inst_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t sb_q[$];

  typedef struct {
    bit          rst, fl, iv;
    logic [31:0] pc, inst;
    bit          ordy;
    bit          e_irdy, e_ov;
    logic [31:0] e_pc, e_inst;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit fl, bit iv, logic [31:0] pc, logic [31:0] inst,
                              bit ordy, bit e_irdy, bit e_ov, logic [31:0] e_pc,
                              logic [31:0] e_inst, int e_cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.inst = inst; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_pc = e_pc; v.e_inst = e_inst; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compares the sampled outputs against the reference queue,
  // then applies this cycle's push/pop/flush/reset to the queue.
  task automatic sb_cycle();
    bit   exp_byp, exp_ov, exp_irdy, do_pop, do_push;
    ent_t head;
    exp_byp  = BYP && (sb_q.size() == 0) && in_valid && !flush;
    exp_ov   = (sb_q.size() != 0) || exp_byp;
    exp_irdy = (sb_q.size() != DEPTH) && !flush;
    chk("sb_count",     32'(count),     32'(sb_q.size()));
    chk("sb_in_ready",  32'(in_ready),  32'(exp_irdy));
    chk("sb_out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      head = (sb_q.size() != 0) ? sb_q[0] : ent_t'({pc_in, inst_in});
      chk("sb_pc_out",   pc_out,   head.pc);
      chk("sb_inst_out", inst_out, head.inst);
    end else begin
      chk("sb_idle_pc",   pc_out,   32'h0);
      chk("sb_idle_inst", inst_out, NOP);
    end
    if (reset || flush) begin
      sb_q.delete();
    end else begin
      do_pop  = exp_ov && out_ready;
      do_push = in_valid && exp_irdy;
      if (do_pop && sb_q.size() != 0) void'(sb_q.pop_front());
      if (do_push && !(exp_byp && out_ready)) sb_q.push_back({pc_in, inst_in});
    end
  endtask

  task automatic step_begin(input bit r, input bit f, input bit v, input logic [31:0] p,
                            input logic [31:0] ins, input bit o);
    reset = r; flush = f; in_valid = v; pc_in = p; inst_in = ins; out_ready = o;
    @(negedge clk);
    sb_cycle();
  endtask

  task automatic step_end();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; inst_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb_q.delete();

`ifndef FETCH_BUFFER_BYPASS_EN
    //              rst fl iv pc            inst          ordy irdy ov  pc_out        inst_out      cnt
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 1, 32'h0,        32'h2000_0000,1,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1,   1,   1,  32'h0,        32'h2000_0000,1));
    tbl.push_back(mk(0, 0, 1, 32'h0,        32'hA000_0000,0,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 1, 32'h4,        32'hA000_0004,0,   1,   1,  32'h0,        32'hA000_0000,1));
    tbl.push_back(mk(0, 0, 1, 32'h8,        32'hA000_0008,0,   1,   1,  32'h0,        32'hA000_0000,2));
    tbl.push_back(mk(0, 0, 1, 32'hC,        32'hA000_000C,0,   1,   1,  32'h0,        32'hA000_0000,3));
    tbl.push_back(mk(0, 0, 1, 32'h10,       32'hB000_0010,0,   0,   1,  32'h0,        32'hA000_0000,4));
    tbl.push_back(mk(0, 0, 1, 32'h10,       32'hB000_0010,1,   0,   1,  32'h0,        32'hA000_0000,4));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1,   1,   1,  32'h4,        32'hA000_0004,3));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1,   1,   1,  32'h8,        32'hA000_0008,2));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1,   1,   1,  32'hC,        32'hA000_000C,1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        1,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 1, 32'h100,      32'hC000_0100,0,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 1, 32'h104,      32'hC000_0104,0,   1,   1,  32'h100,      32'hC000_0100,1));
    tbl.push_back(mk(0, 0, 1, 32'h108,      32'hC000_0108,0,   1,   1,  32'h100,      32'hC000_0100,2));
    tbl.push_back(mk(0, 1, 1, 32'h10C,      32'hC000_010C,1,   0,   1,  32'h100,      32'hC000_0100,3));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 1, 32'h200,      32'hD000_0200,0,   1,   0,  32'h0,        NOP,          0));
    tbl.push_back(mk(0, 0, 1, 32'h204,      32'hD000_0204,1,   1,   1,  32'h200,      32'hD000_0200,1));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0,   1,   1,  32'h204,      32'hD000_0204,1));
    tbl.push_back(mk(0, 0, 1, 32'h208,      32'hD000_0208,0,   1,   1,  32'h204,      32'hD000_0204,1));
    tbl.push_back(mk(1, 0, 1, 32'h20C,      32'hD000_020C,0,   1,   1,  32'h204,      32'hD000_0204,2));
    tbl.push_back(mk(0, 0, 0, 32'h0,        32'h0,        0,   1,   0,  32'h0,        NOP,          0));

    for (int i = 0; i < tbl.size(); i++) begin
      step_begin(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_irdy));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_pc_out", i),    pc_out,         tbl[i].e_pc);
      chk($sformatf("tbl%0d_inst_out", i),  inst_out,       tbl[i].e_inst);
      chk($sformatf("tbl%0d_count", i),     32'(count),     32'(tbl[i].e_cnt));
      step_end();
    end
`else
    // Bypass: empty buffer, pair taken in the same cycle, never stored.
    step_begin(0, 0, 1, 32'h8, 32'h0100_0820, 1);
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    chk("bp_pc_out",    pc_out,         32'h8);
    chk("bp_inst_out",  inst_out,       32'h0100_0820);
    chk("bp_count",     32'(count),     32'h0);
    step_end();
    step_begin(0, 0, 0, 32'h0, 32'h0, 0);
    chk("bp_count_after", 32'(count),   32'h0);
    chk("bp_valid_after", 32'(out_valid), 32'h0);
    step_end();
    // Bypassed but not taken: must be stored.
    step_begin(0, 0, 1, 32'h40, 32'h0000_4040, 0);
    chk("bp_hold_valid", 32'(out_valid), 32'h1);
    step_end();
    step_begin(0, 0, 0, 32'h0, 32'h0, 1);
    chk("bp_hold_count", 32'(count), 32'h1);
    chk("bp_hold_pc",    pc_out,     32'h40);
    step_end();
`endif

    // Steady stream at occupancy 2: pointers wrap, PCs stay contiguous.
    step_begin(0, 0, 1, 32'h300, 32'hE000_0300, 0);
    step_end();
    step_begin(0, 0, 1, 32'h304, 32'hE000_0304, 0);
    step_end();
    for (int k = 0; k < 10; k++) begin
      step_begin(0, 0, 1, 32'h308 + 32'(4 * k), 32'hE000_0308 + 32'(4 * k), 1);
      chk($sformatf("wrap%0d_count", k), 32'(count), 32'h2);
      chk($sformatf("wrap%0d_pc", k),    pc_out,     32'h300 + 32'(4 * k));
      step_end();
    end

    // Randomised traffic: a filling phase then a draining phase.
    for (int n = 0; n < 300; n++) begin
      bit r, f, v, o;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = (n < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step_begin(r, f, v, 32'h1000 + 32'(4 * n), $urandom, o);
      step_end();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
